sign_sat_narrow: RTL
====================

Name: sign_sat_narrow

Overview:
Return path for the 16-lane signed adder output. It takes packed 16x9-bit signed sums and requantizes each lane back to 8-bit signed. Each lane gets an arithmetic right shift, round-half-up and saturation. It is a 2-stage pipeline with valid/ready handshake on both sides, so it can sit between the lane adder and the next 8-bit processing layer under backpressure.

Parameters:
LANES, 16, number of packed lanes
W_IN, 9, signed input lane width
W_OUT, 8, signed output lane width
CNT_W, 16, width of saturation event counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  upstream data valid
in_ready  output  1  block can accept in_data this cycle
in_data  input  W_IN*LANES  packed signed lanes; lane i = in_data[W_IN*(i+1)-1 : W_IN*i]
in_shift  input  4  right-shift amount, sampled with in_data; values > W_IN-1 clamp to W_IN-1
out_valid  output  1  out_data valid
out_ready  input  1  downstream accepts out_data
out_data  output  W_OUT*LANES  packed signed lanes, same lane ordering as in_data
sat_mask  output  LANES  per-lane saturation flag aligned with out_data
sat_cnt  output  CNT_W  count of output transfers with any lane saturated
cnt_clr  input  1  synchronous clear of sat_cnt

Behaviour:
- Reset (async assert, sync release): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, sat_mask=0, sat_cnt=0. Reset mid-operation discards both stages. No partial transfer completes.
- Handshake: transfer occurs when valid && ready on the same edge. Data/mask are held stable while out_valid=1 && out_ready=0. out_valid never drops without a transfer.
- Pipeline enables: s2_en = !s2_valid || out_ready; s1_en = !s1_valid || s2_en; in_ready = s1_en (combinational from out_ready).
- Throughput: 1 vector/cycle with out_ready held high. Latency: exactly 2 cycles from input transfer to out_valid.
- Stage 1 (on s1_en): per lane, sign-extend x to W_IN+1 bits. bias = (sh==0) ? 0 : 1<<(sh-1). r = (x + bias) >>> sh, kept at W_IN+1 bits. Register r[] and s1_valid=in_valid.
- Stage 2 (on s2_en): per lane, if r > 2^(W_OUT-1)-1 output 127 and set sat_mask[i]; if r < -2^(W_OUT-1) output -128 and set sat_mask[i]; else output r[W_OUT-1:0] and clear sat_mask[i]. s2_valid=s1_valid.
- Bubbles: a stage loading with valid=0 clears its valid. Data registers may hold stale values, but out_data and sat_mask are only meaningful when out_valid=1.
- sat_cnt: increments by 1 on each output transfer with |sat_mask. It saturates at 2^CNT_W-1 and does not wrap. cnt_clr has priority over increment; clear and transfer in the same cycle gives 0.
- Lanes are fully independent. There is no cross-lane carry.

Decomposition:
- Shared package: LANES, W_IN, W_OUT defaults; the lane slice helper (offset = W*i); saturation bound constants SAT_MAX / SAT_MIN derived from W_OUT.
- One natural sub-module, sat_narrow_lane: stage-1 round/shift math and stage-2 clamp for a single lane, purely combinational. Instantiate it LANES times via generate. Valid/ready control, registers and sat_cnt stay in the top.

Test Plan:
- in_shift=1. Lanes 0..3 = 9'h0FF (255), 9'h1FD (-3), 9'h005 (5), 9'h100 (-256); rest 0 -> after 2 cycles, out lanes 0..3 = 8'h7F, 8'hFF, 8'h03, 8'h80. sat_mask = 16'h0001. sat_cnt=1.
- in_shift=0. All lanes 9'h100 -> all out lanes 8'h80, sat_mask=16'hFFFF. Lanes 9'h07F -> 8'h7F, mask 0.
- in_shift=15 (clamped to 8). Lane 9'h0FF -> 8'h01; lane 9'h100 -> 8'hFF. No saturation.
- Backpressure: out_ready=0, drive in_valid=1 with vectors V0..V3 for 4 cycles -> V0 and V1 accepted, in_ready=0 from the 3rd cycle. out_data holds V0 stable. Release out_ready -> V0, V1, V2, V3 emerge in order, no loss or duplication.
- Counter: force sat_cnt near max (stream 2^CNT_W+2 saturating vectors, or use a reduced CNT_W=4 build) -> holds at 4'hF. cnt_clr with a simultaneous saturating transfer -> 0.
- Reset: assert rst_n=0 while both stages are valid -> out_valid, sat_mask and sat_cnt are 0 immediately (async). After release, the first new vector appears 2 cycles after acceptance.

Source files
------------

// File: rtl/sign_sat_narrow_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sign_sat_narrow_pkg
// Description : Shared defaults, lane slicing helper and saturation bounds
//               for the 9-bit to 8-bit signed requantizer.
// Revision    : 1.0 - initial release
// ============================================================================
package sign_sat_narrow_pkg;

  localparam int LANES_DEF = 16;
  localparam int W_IN_DEF  = 9;
  localparam int W_OUT_DEF = 8;
  localparam int CNT_W_DEF = 16;

  // Largest and smallest values representable in a signed W-bit lane
  function automatic int sat_max(input int w);
    return (2 ** (w - 1)) - 1;
  endfunction

  function automatic int sat_min(input int w);
    return -(2 ** (w - 1));
  endfunction

  // Saturation bounds for the default output lane width
  localparam int SAT_MAX = (2 ** (W_OUT_DEF - 1)) - 1;
  localparam int SAT_MIN = -(2 ** (W_OUT_DEF - 1));

  // Bit offset of lane i inside a packed vector of W-bit lanes
  function automatic int lane_off(input int w, input int i);
    return w * i;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sat_narrow_lane.sv
`default_nettype none
// ============================================================================
// Module      : sat_narrow_lane
// Description : Single-lane combinational math. Front half rounds and shifts
//               an input sample; back half clamps a registered intermediate
//               into the signed output range.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_narrow_lane
  import sign_sat_narrow_pkg::*;
#(
  parameter int W_IN   = W_IN_DEF,
  parameter int W_OUT  = W_OUT_DEF,
  parameter int SAT_HI = SAT_MAX,
  parameter int SAT_LO = SAT_MIN
) (
  input  logic [W_IN-1:0]         x,
  input  logic [3:0]              shift,
  output logic signed [W_IN:0]    r,
  input  logic signed [W_IN:0]    r_q,
  output logic [W_OUT-1:0]        y,
  output logic                    sat
);

  localparam logic [3:0]           SH_MAX = 4'(W_IN - 1);
  localparam logic signed [W_IN:0] HI     = (W_IN + 1)'(SAT_HI);
  localparam logic signed [W_IN:0] LO     = (W_IN + 1)'(SAT_LO);

  logic [3:0]           sh;
  logic signed [W_IN:0] x_ext;
  logic signed [W_IN:0] bias;
  logic signed [W_IN:0] sum;

  // Round-half-up then arithmetic shift; one guard bit keeps x+bias exact
  always_comb begin
    sh    = (shift > SH_MAX) ? SH_MAX : shift;
    x_ext = {x[W_IN-1], x};
    bias  = '0;
    if (sh != 4'd0) begin
      bias = {{W_IN{1'b0}}, 1'b1} << (sh - 4'd1);
    end
    sum = x_ext + bias;
    r   = sum >>> sh;
  end

  // Clamp the registered intermediate into the signed output range
  always_comb begin
    y   = r_q[W_OUT-1:0];
    sat = 1'b0;
    if (r_q > HI) begin
      y   = HI[W_OUT-1:0];
      sat = 1'b1;
    end else if (r_q < LO) begin
      y   = LO[W_OUT-1:0];
      sat = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sign_sat_narrow.sv
`default_nettype none
// ============================================================================
// Module      : sign_sat_narrow
// Description : Two-stage valid/ready pipeline that requantizes packed signed
//               9-bit lanes to 8-bit signed with rounding shift, saturation,
//               a per-lane saturation mask and a saturating event counter.
// Revision    : 1.0 - initial release
// ============================================================================
module sign_sat_narrow
  import sign_sat_narrow_pkg::*;
#(
  parameter int LANES = LANES_DEF,
  parameter int W_IN  = W_IN_DEF,
  parameter int W_OUT = W_OUT_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W_IN*LANES-1:0]    in_data,
  input  logic [3:0]               in_shift,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W_OUT*LANES-1:0]   out_data,
  output logic [LANES-1:0]         sat_mask,
  output logic [CNT_W-1:0]         sat_cnt,
  input  logic                     cnt_clr
);

  localparam int W_R = W_IN + 1;

  logic                       s1_valid;
  logic                       s2_valid;
  logic                       s1_en;
  logic                       s2_en;
  logic                       out_xfer;
  logic [LANES-1:0][W_R-1:0]  s1_r;
  logic [LANES-1:0][W_R-1:0]  r_next;
  logic [W_OUT*LANES-1:0]     y_next;
  logic [LANES-1:0]           sat_next;

  // A stage may load when it is empty or its contents move on this edge
  assign s2_en     = !s2_valid || out_ready;
  assign s1_en     = !s1_valid || s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s2_valid;
  assign out_xfer  = s2_valid && out_ready;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sat_narrow_lane #(
      .W_IN   (W_IN),
      .W_OUT  (W_OUT),
      .SAT_HI (sat_max(W_OUT)),
      .SAT_LO (sat_min(W_OUT))
    ) u_lane (
      .x     (in_data[lane_off(W_IN, i) +: W_IN]),
      .shift (in_shift),
      .r     (r_next[i]),
      .r_q   (s1_r[i]),
      .y     (y_next[lane_off(W_OUT, i) +: W_OUT]),
      .sat   (sat_next[i])
    );
  end

  // Stage 1: capture rounded/shifted intermediates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_r     <= '0;
    end else if (s1_en) begin
      s1_valid <= in_valid;
      s1_r     <= r_next;
    end
  end

  // Stage 2: capture clamped outputs and saturation flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      sat_mask <= '0;
    end else if (s2_en) begin
      s2_valid <= s1_valid;
      out_data <= y_next;
      sat_mask <= sat_next;
    end
  end

  // Count output transfers carrying any saturated lane; clear wins, no wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt <= '0;
    end else if (cnt_clr) begin
      sat_cnt <= '0;
    end else if (out_xfer && (|sat_mask) && (sat_cnt != {CNT_W{1'b1}})) begin
      sat_cnt <= sat_cnt + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire
